// File: rtl/pe_resp_router.sv
// Response router: in-order tracker of the slave indices of accepted requests.
// Each response is accepted only from the slave at the head of the tracker.
module pe_resp_router #(
  parameter  int N_SLAVE         = 16,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int LOG_SLAVE       = $clog2(N_SLAVE),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_req_i,
  input  logic                          data_gnt_i,
  input  logic [LOG_SLAVE-1:0]          data_slave_sel_i,
  input  logic [N_SLAVE-1:0]            slv_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0] slv_r_rdata_i,
  input  logic [N_SLAVE-1:0]            slv_r_opc_i,
  output logic                          data_r_valid_o,
  output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
  output logic                          data_r_opc_o,
  output logic                          block_req_o,
  output logic [CNT_W-1:0]              outstanding_o,
  output logic                          err_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  logic [LOG_SLAVE-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic                  r_opc_q;
  logic                  err_q, err_d;

  logic [LOG_SLAVE-1:0]  head;
  logic [N_SLAVE-1:0]    head_mask;
  logic                  empty, full, pop, push, push_req, overflow, stray;
  logic [DATA_WIDTH-1:0] head_rdata;

  always_comb begin
    head      = fifo_q[rd_ptr_q];
    empty     = (cnt_q == '0);
    full      = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    head_mask = '0;
    if (!empty) head_mask[head] = 1'b1;
    pop       = |(slv_r_valid_i & head_mask);
    // Any valid outside the head slot (all of them when empty) is a protocol error.
    stray     = |(slv_r_valid_i & ~head_mask);
    push_req  = data_req_i & data_gnt_i;
    // When full, a same-cycle pop frees the slot the push lands in.
    push      = push_req & (!full | pop);
    overflow  = push_req & full & !pop;
    head_rdata = slv_r_rdata_i[int'(head)*DATA_WIDTH +: DATA_WIDTH];

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    err_d    = err_q | overflow | stray;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= data_slave_sel_i;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      r_valid_q <= pop;
      if (pop) begin
        r_rdata_q <= head_rdata;
        r_opc_q   <= slv_r_opc_i[head];
      end
      err_q     <= err_d;
    end
  end

  assign data_r_valid_o = r_valid_q;
  assign data_r_rdata_o = r_rdata_q;
  assign data_r_opc_o   = r_opc_q;
  assign block_req_o    = full;
  assign outstanding_o  = cnt_q;
  assign err_o          = err_q;

endmodule

// File: doc/pe_resp_router.md
PE_RESP_ROUTER -- requirements
Module: pe_resp_router

Interface
REQ-001 Parameter N_SLAVE, 16, number of slave ports; the response side of the peripheral interconnect, one slave port per routing index.
REQ-002 Parameter DATA_WIDTH, 32, response data width.
REQ-003 Parameter MAX_OUTSTANDING, 4, tracker depth; a power of two, 2..16.
REQ-004 Derived LOG_SLAVE = log2(N_SLAVE); index N_SLAVE-1 is the default/unmapped slave.
REQ-005 Derived CNT_W = log2(MAX_OUTSTANDING)+1.
REQ-006 clk  in  1  single clock; all state rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 data_req_i  in  1  master request, as driven by the request-side decoder.
REQ-009 data_gnt_i  in  1  grant returned to the master; request accepted when data_req_i&data_gnt_i.
REQ-010 data_slave_sel_i  in  LOG_SLAVE  routing index of the accepted request.
REQ-011 slv_r_valid_i  in  N_SLAVE  per-slave response valid, one-cycle pulse per response.
REQ-012 slv_r_rdata_i  in  N_SLAVE*DATA_WIDTH  per-slave response data; slave k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 slv_r_opc_i  in  N_SLAVE  per-slave error flag.
REQ-014 data_r_valid_o  out  1  response valid to master.
REQ-015 data_r_rdata_o  out  DATA_WIDTH  response data to master.
REQ-016 data_r_opc_o  out  1  response error flag to master.
REQ-017 block_req_o  out  1  request-side gate; master requests SHALL be held off while high.
REQ-018 outstanding_o  out  CNT_W  number of accepted, unanswered requests.
REQ-019 err_o  out  1  sticky protocol-error flag.

Function
REQ-020 The block SHALL hold an in-order FIFO of slave indices, MAX_OUTSTANDING entries deep, with write pointer, read pointer and count.
REQ-021 Push: on data_req_i&data_gnt_i, data_slave_sel_i SHALL be written at the write pointer.
REQ-022 Pop: when FIFO not empty and slv_r_valid_i[head] is 1, the head entry SHALL be retired.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; this SHALL hold when full and when count is 1.
REQ-024 Pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-025 The accepted response SHALL be registered: data_r_valid_o=1 exactly one cycle after the pop cycle, with the popped slave's rdata/opc captured in that cycle.
REQ-026 data_r_valid_o SHALL be 0 in all other cycles; rdata/opc hold their last value when valid is 0.
REQ-027 block_req_o SHALL be 1 when count==MAX_OUTSTANDING, combinational from count; it SHALL fall in the cycle after a pop from full.
REQ-028 outstanding_o SHALL equal count.
REQ-029 A push while full without a same-cycle pop SHALL be dropped and set err_o.
REQ-030 A slv_r_valid_i bit that does not match the head index, or any bit set while empty, SHALL be dropped and set err_o; a valid head response in the same cycle is still accepted.
REQ-031 err_o SHALL remain 1 until reset.

Reset
REQ-032 While rst=1: pointers, count=0, data_r_valid_o=0, data_r_rdata_o=0, data_r_opc_o=0, err_o=0, block_req_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding entries; late responses after release SHALL set err_o.

Verification
REQ-034 Single: accept to slave 3; slv_r_valid_i[3]=1 with rdata 0xCAFE0003 two cycles later -> next cycle data_r_valid_o=1, rdata=0xCAFE0003, opc=0, outstanding 1->0.
REQ-035 In-order: accept to slaves 2, 5, 15 (unmapped default); respond 2, 5, 15 with opc on 15 -> three valid pulses in order, last with data_r_opc_o=1, err_o=0.
REQ-036 Full: four accepts, no responses -> outstanding=4, block_req_o=1; fifth accept -> dropped, err_o=1; one response -> block_req_o=0 next cycle.
REQ-037 Full, push and pop in the same cycle -> count stays 4, new entry retained, err_o=0, with eight further push/pop pairs exercising pointer wrap.
REQ-038 Out-of-order: head=slave 1, slv_r_valid_i[4]=1 -> no data_r_valid_o, err_o=1, head still 1.
REQ-039 Reset with 3 outstanding -> outputs 0 immediately (async); after release a slave response -> err_o=1, no valid.
